// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W integer register file with optional writeback bypass and a per-register pending-write scoreboard
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int BYPASS     = 1,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2,
    output logic                  o_busy1,
    output logic                  o_busy2,
    input  logic                  i_issue_valid,
    input  logic [ADDR_WIDTH-1:0] i_issue_rd,
    output logic                  o_issue_ready,
    input  logic                  i_wb_valid,
    input  logic                  i_wb_wen,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_wb_done,
    input  logic                  i_flush
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] rf [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt [NUM_REGS];
    logic [IDX_W-1:0]      r1_idx, r2_idx, iss_idx, wb_idx;
    logic [NUM_REGS-1:0]   inc_vec, dec_vec;
    logic                  wb_write, issue_acc, hit1, hit2;

    assign r1_idx  = i_raddr1[IDX_W-1:0];
    assign r2_idx  = i_raddr2[IDX_W-1:0];
    assign iss_idx = i_issue_rd[IDX_W-1:0];
    assign wb_idx  = i_wb_addr[IDX_W-1:0];

    // Upper address bits alias onto the implemented registers and are deliberately ignored
    if (IDX_W < ADDR_WIDTH) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^{i_raddr1[ADDR_WIDTH-1:IDX_W], i_raddr2[ADDR_WIDTH-1:IDX_W],
                             i_issue_rd[ADDR_WIDTH-1:IDX_W], i_wb_addr[ADDR_WIDTH-1:IDX_W]};
    end

    assign wb_write      = i_wb_valid & i_wb_wen & (wb_idx != '0);
    assign o_issue_ready = (iss_idx == '0) | (cnt[iss_idx] != CNT_MAX) | (wb_write & (wb_idx == iss_idx));
    assign issue_acc     = i_issue_valid & o_issue_ready & (iss_idx != '0);
    assign inc_vec       = issue_acc ? (NUM_REGS'(1) << iss_idx) : '0;
    assign dec_vec       = wb_write ? (NUM_REGS'(1) << wb_idx) : '0;

    assign hit1     = (BYPASS != 0) & wb_write & (wb_idx == r1_idx);
    assign hit2     = (BYPASS != 0) & wb_write & (wb_idx == r2_idx);
    assign o_rdata1 = (r1_idx == '0) ? '0 : hit1 ? i_wb_data : rf[r1_idx];
    assign o_rdata2 = (r2_idx == '0) ? '0 : hit2 ? i_wb_data : rf[r2_idx];
    assign o_busy1  = (r1_idx != '0) & (hit1 ? (cnt[r1_idx] > CNT_WIDTH'(1)) : (cnt[r1_idx] != '0));
    assign o_busy2  = (r2_idx != '0) & (hit2 ? (cnt[r2_idx] > CNT_WIDTH'(1)) : (cnt[r2_idx] != '0));

    // Register array: writeback updates the addressed entry, x0 is never written
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
        end else if (wb_write) begin
            rf[wb_idx] <= i_wb_data;
        end
    end

    // Pending-write counters: flush clears all, otherwise issue increments and writeback decrements (floor 0)
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n || i_flush) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) cnt[r] <= cnt[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // Retire pulse: follows any writeback transaction by one cycle, regardless of write enable
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) o_wb_done <= 1'b0;
        else o_wb_done <= i_wb_valid;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random checks of two register-file builds (bypass on/off) against a behavioural model
`timescale 1ns/100ps
module tb_regfile_scoreboard;
    logic        clk = 0, rst_n = 0;
    logic [4:0]  raddr1 = 0, raddr2 = 0, issue_rd = 0, wb_addr = 0;
    logic        issue_valid = 0, wb_valid = 0, wb_wen = 0, flush = 0;
    logic [31:0] wb_data = 0;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        bsy1_b, bsy2_b, bsy1_n, bsy2_n, rdy_b, rdy_n, done_b, done_n;

    int n_checks = 0, n_errors = 0;

    logic [31:0] m_rf [16];
    int          m_cnt [16];
    logic        m_done;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_rdata1(rd1_b), .o_rdata2(rd2_b), .o_busy1(bsy1_b), .o_busy2(bsy2_b),
        .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(rdy_b),
        .i_wb_valid(wb_valid), .i_wb_wen(wb_wen), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_wb_done(done_b), .i_flush(flush));

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .i_clock(clk), .i_reset_n(rst_n), .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_rdata1(rd1_n), .o_rdata2(rd2_n), .o_busy1(bsy1_n), .o_busy2(bsy2_n),
        .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(rdy_n),
        .i_wb_valid(wb_valid), .i_wb_wen(wb_wen), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_wb_done(done_n), .i_flush(flush));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wb_hits(input logic [4:0] a);
        return wb_valid && wb_wen && (wb_addr % 16) != 0 && (wb_addr % 16) == (a % 16);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a % 16 == 0) return 0;
        if (byp && wb_hits(a)) return wb_data;
        return m_rf[a % 16];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a % 16 == 0) return 0;
        if (byp && wb_hits(a)) return m_cnt[a % 16] > 1;
        return m_cnt[a % 16] != 0;
    endfunction

    function automatic logic exp_ready();
        return (issue_rd % 16 == 0) || m_cnt[issue_rd % 16] < 3 || wb_hits(issue_rd);
    endfunction

    // Reference model: architectural state advanced from the rules at each clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_rf[i] = 0;
                m_cnt[i] = 0;
            end
            m_done = 0;
        end else begin
            int wi, ii;
            bit wbw, acc;
            wi = wb_addr % 16;
            ii = issue_rd % 16;
            wbw = wb_valid && wb_wen && wi != 0;
            acc = issue_valid && exp_ready() && ii != 0;
            if (flush) begin
                for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            end else begin
                if (acc) m_cnt[ii] = m_cnt[ii] + 1;
                if (wbw) m_cnt[wi] = (m_cnt[wi] > 0) ? m_cnt[wi] - 1 : 0;
            end
            if (wbw) m_rf[wi] = wb_data;
            m_done = wb_valid;
        end
    end

    // Compare both builds against the model away from the clock edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rdata1_byp", rd1_b, exp_rd(raddr1, 1));
            chk("rdata2_byp", rd2_b, exp_rd(raddr2, 1));
            chk("rdata1_nobyp", rd1_n, exp_rd(raddr1, 0));
            chk("rdata2_nobyp", rd2_n, exp_rd(raddr2, 0));
            chk("busy1_byp", bsy1_b, exp_busy(raddr1, 1));
            chk("busy2_byp", bsy2_b, exp_busy(raddr2, 1));
            chk("busy1_nobyp", bsy1_n, exp_busy(raddr1, 0));
            chk("busy2_nobyp", bsy2_n, exp_busy(raddr2, 0));
            chk("ready_byp", rdy_b, exp_ready());
            chk("ready_nobyp", rdy_n, exp_ready());
            chk("done_byp", done_b, m_done);
            chk("done_nobyp", done_n, m_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        issue_valid = 0;
        wb_valid = 0;
        wb_wen = 0;
        flush = 0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1;
        wb_wen = 1;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic issue(input logic [4:0] a);
        issue_valid = 1;
        issue_rd = a;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("reset_busy", bsy1_b, 0);
        chk("reset_done", done_b, 0);
        // write then read, x0 write dropped, retire pulse
        wb(5, 32'hDEADBEEF);
        tick();
        raddr1 = 5;
        #2 chk("wr_rd", rd1_b, 32'hDEADBEEF);
        chk("done_pulse", done_b, 1);
        wb(0, 32'h55);
        tick();
        raddr2 = 0;
        #2 chk("x0_rd", rd2_b, 0);
        chk("done_held", done_b, 1);
        tick();
        #2 chk("done_clear", done_b, 0);
        // bypass vs array-only read
        raddr1 = 7;
        wb(7, 32'h1234);
        #2 chk("bypass_on", rd1_b, 32'h1234);
        chk("bypass_off", rd1_n, 0);
        tick();
        #2 chk("nobyp_after", rd1_n, 32'h1234);
        // scoreboard saturation and drain
        raddr1 = 3;
        repeat (3) begin
            issue(3);
            tick();
        end
        issue(3);
        #2 chk("full_not_ready", rdy_b, 0);
        chk("full_busy", bsy1_b, 1);
        issue_valid = 0;
        wb(3, 1); tick();
        #2 chk("drain1_busy", bsy1_b, 1);
        wb(3, 2); tick();
        #2 chk("drain2_busy", bsy1_b, 1);
        wb(3, 3); tick();
        #2 chk("drain3_busy", bsy1_b, 0);
        // simultaneous issue and writeback
        raddr1 = 4;
        issue(4); tick();
        issue(4); wb(4, 32'h44); tick();
        #2 chk("simul_busy", bsy1_b, 1);
        chk("simul_data", rd1_b, 32'h44);
        wb(4, 32'h45); tick();
        #2 chk("simul_drained", bsy1_b, 0);
        // flush with concurrent issue, then stale writeback
        issue(2); tick();
        issue(2); tick();
        flush = 1; issue(9); tick();
        raddr1 = 9; raddr2 = 2;
        #2 chk("flush_rd9", bsy1_b, 0);
        chk("flush_rd2", bsy2_b, 0);
        wb(2, 32'h22); tick();
        #2 chk("stale_busy", bsy2_b, 0);
        chk("stale_data", rd2_b, 32'h22);
        // upper address bits alias in a 16-entry file
        wb(17, 32'hA1A5); tick();
        raddr1 = 1; raddr2 = 17;
        #2 chk("alias_rd1", rd1_b, 32'hA1A5);
        chk("alias_rd17", rd2_b, 32'hA1A5);
        // asynchronous reset mid-run
        issue(6); tick();
        wb(12, 7); tick();
        raddr1 = 6;
        #1 chk("pre_rst_done", done_b, 1);
        chk("pre_rst_busy", bsy1_b, 1);
        rst_n = 0;
        #1 chk("rst_done", done_b, 0);
        chk("rst_busy", bsy1_b, 0);
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1 chk("rst_rd1", rd1_b, 0);
            chk("rst_rd2", rd2_n, 0);
            chk("rst_busy2", bsy2_b, 0);
        end
        @(posedge clk);
        #1 rst_n = 1;
        // randomized traffic biased toward a few registers to create hazards
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            raddr1 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            issue_valid = $urandom_range(0, 1);
            issue_rd = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wb_valid = $urandom_range(0, 1);
            wb_wen = ($urandom_range(0, 4) != 0);
            wb_addr = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wb_data = $urandom;
            flush = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
